// File: rtl/captura_pkg.sv
// captura_pkg: shared FSM states, active-low 7-segment codes (bit6=g..bit0=a) and default parameters.
package captura_pkg;
  typedef enum logic [1:0] {ESPERA, FILTRA, FIXO} estado_t;
  localparam int ESTAVEL_PAD = 2;
  localparam int TIMEOUT_PAD = 1024;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
endpackage

// File: rtl/decod7seg.sv
// decod7seg: active-low 7-segment pattern to nibble with valid/blank flags.
// Define CAPTURA_HEX_EN to also accept the A-F glyphs.
module decod7seg
  import captura_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       valido,
  output logic       apagado
);
  always_comb begin
    nib = 4'h0;
    valido = 1'b1;
    apagado = seg == SEG_BLANK;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
`ifdef CAPTURA_HEX_EN
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      SEG_D: nib = 4'hD;
      SEG_E: nib = 4'hE;
      SEG_F: nib = 4'hF;
`else
`endif
      default: valido = 1'b0;
    endcase
  end
endmodule

// File: rtl/captura_varredura.sv
// captura_varredura: debounces a multiplexed 4-digit 7-segment scan into per-digit values,
// with frame pulse and stall watchdog. Hex glyphs decode only with CAPTURA_HEX_EN defined.
module captura_varredura
  import captura_pkg::*;
#(
  parameter int ESTAVEL = ESTAVEL_PAD,
  parameter int TIMEOUT = TIMEOUT_PAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digito,
  input  logic [6:0]  segmentos,
  output logic [15:0] valores,
  output logic [3:0]  validos,
  output logic [3:0]  apagado,
  output logic [3:0]  invalido,
  output logic        quadro,
  output logic        travado
);
  estado_t estado_q, estado_d;
  logic [3:0] dig_q, prv_dig_q, cnt_q, cnt_d, cnt_inc, mask_q, mask_d;
  logic [6:0] seg_q, prv_seg_q;
  logic [15:0] valores_q, valores_d, wd_q, wd_d;
  logic [3:0] validos_q, validos_d, apagado_q, apagado_d, invalido_q, invalido_d;
  logic [3:0] nib;
  logic [1:0] idx;
  logic legal, same, commit, dec_valido, dec_apagado;
  decod7seg u_dec (.seg(seg_q), .nib(nib), .valido(dec_valido), .apagado(dec_apagado));
  always_comb begin
    legal = (dig_q != 4'd0) && ((dig_q & (dig_q - 4'd1)) == 4'd0);
    same = dig_q == prv_dig_q && seg_q == prv_seg_q;
    cnt_inc = (estado_q == ESPERA || !same) ? 4'd1 : cnt_q + 4'd1;
    commit = legal && !(estado_q == FIXO && same) && cnt_inc == 4'(ESTAVEL);
    estado_d = !legal ? ESPERA : (commit || (estado_q == FIXO && same)) ? FIXO : FILTRA;
    cnt_d = legal ? cnt_inc : 4'd0;
    idx = {dig_q[3] | dig_q[2], dig_q[3] | dig_q[1]};
    valores_d = valores_q;
    validos_d = validos_q;
    apagado_d = apagado_q;
    invalido_d = invalido_q;
    if (commit) begin
      if (dec_valido) valores_d[{idx, 2'b00} +: 4] = nib;
      validos_d[idx] = dec_valido;
      apagado_d[idx] = dec_apagado;
      invalido_d[idx] = !dec_valido && !dec_apagado;
    end
    // a full mask clears in the pulse cycle, but a commit landing then still counts
    mask_d = (mask_q == 4'hF ? 4'd0 : mask_q) | (commit ? dig_q : 4'd0);
    wd_d = commit ? 16'd0 : (wd_q == 16'(TIMEOUT)) ? wd_q : wd_q + 16'd1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
      dig_q <= '0;
      seg_q <= '0;
      prv_dig_q <= '0;
      prv_seg_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      wd_q <= '0;
      valores_q <= '0;
      validos_q <= '0;
      apagado_q <= '0;
      invalido_q <= '0;
    end else begin
      estado_q <= estado_d;
      dig_q <= digito;
      seg_q <= segmentos;
      prv_dig_q <= dig_q;
      prv_seg_q <= seg_q;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      wd_q <= wd_d;
      valores_q <= valores_d;
      validos_q <= validos_d;
      apagado_q <= apagado_d;
      invalido_q <= invalido_d;
    end
  end
  assign valores = valores_q;
  assign validos = validos_q;
  assign apagado = apagado_q;
  assign invalido = invalido_q;
  assign quadro = mask_q == 4'hF;
  assign travado = wd_q == 16'(TIMEOUT);
endmodule
